// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: RV32I fetch stage (PCF, next-PC select) plus IF/ID pipeline register.
// Define PERF_CNT_EN to build the stall/flush/fetch performance counters.
module fetch_ifid_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             FlushD,
  input  logic             PcSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [31:0]      InstrF,
  output logic [XLEN-1:0]  PCF,
  output logic [31:0]      InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             ValidD,
  input  logic             PerfClr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] FetchCnt
);
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pcd;
  logic [XLEN-1:0] r_pcp4d;
  logic            r_valid;
  assign w_pc_plus4 = r_pc + XLEN'(4);
  // A redirect must never be lost, so it overrides a fetch stall.
  assign w_pc_next = PcSrcE ? PCTargetE : stallF ? r_pc : w_pc_plus4;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_pc <= RESET_PC;
    else r_pc <= w_pc_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_instr <= NOP_INSTR;
      r_pcd   <= '0;
      r_pcp4d <= '0;
      r_valid <= 1'b0;
    end else if (FlushD) begin
      r_instr <= NOP_INSTR;
      r_pcd   <= '0;
      r_pcp4d <= '0;
      r_valid <= 1'b0;
    end else if (!stallD) begin
      r_instr <= InstrF;
      r_pcd   <= r_pc;
      r_pcp4d <= w_pc_plus4;
      r_valid <= 1'b1;
    end
  assign PCF      = r_pc;
  assign InstrD   = r_instr;
  assign PCD      = r_pcd;
  assign PCPlus4D = r_pcp4d;
  assign ValidD   = r_valid;
`ifdef PERF_CNT_EN
  logic             w_stall_cyc;
  logic             w_accept;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_fetch_cnt;
  assign w_stall_cyc = stallD & ~FlushD;
  assign w_accept    = ~stallD & ~FlushD;
  // Counters saturate at all-ones; a clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fetch_cnt <= '0;
    end else if (PerfClr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fetch_cnt <= '0;
    end else begin
      r_stall_cnt <= (w_stall_cyc && !(&r_stall_cnt)) ? r_stall_cnt + CNT_W'(1) : r_stall_cnt;
      r_flush_cnt <= (FlushD && !(&r_flush_cnt)) ? r_flush_cnt + CNT_W'(1) : r_flush_cnt;
      r_fetch_cnt <= (w_accept && !(&r_fetch_cnt)) ? r_fetch_cnt + CNT_W'(1) : r_fetch_cnt;
    end
  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
  assign FetchCnt = r_fetch_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = PerfClr;
  assign StallCnt = '0;
  assign FlushCnt = '0;
  assign FetchCnt = '0;
`endif
endmodule

// File: tb/tb_fetch_ifid_stage.sv
// tb_fetch_ifid_stage: directed self-checking bench for fetch_ifid_stage (either PERF_CNT_EN build).
module tb_fetch_ifid_stage;
  logic        clk = 1'b0;
  logic        reset, stallF, stallD, FlushD, PcSrcE, PerfClr;
  logic [31:0] PCTargetE, InstrF, PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [31:0] StallCnt, FlushCnt, FetchCnt;
  int n_cmp = 0;
  int n_err = 0;
  fetch_ifid_stage dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .FlushD(FlushD),
    .PcSrcE(PcSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF), .PCF(PCF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .PerfClr(PerfClr), .StallCnt(StallCnt), .FlushCnt(FlushCnt), .FetchCnt(FetchCnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] im(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  assign InstrF = im(PCF);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_d(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] pc4, input logic v);
    chk({tag, ".InstrD"}, InstrD, ins);
    chk({tag, ".PCD"}, PCD, pc);
    chk({tag, ".PCPlus4D"}, PCPlus4D, pc4);
    chk({tag, ".ValidD"}, {31'b0, ValidD}, {31'b0, v});
  endtask
  task automatic chk_cnt(input string tag, input int s, input int f, input int a);
`ifdef PERF_CNT_EN
    chk({tag, ".StallCnt"}, StallCnt, s);
    chk({tag, ".FlushCnt"}, FlushCnt, f);
    chk({tag, ".FetchCnt"}, FetchCnt, a);
`else
    chk({tag, ".StallCnt"}, StallCnt, 0);
    chk({tag, ".FlushCnt"}, FlushCnt, 0);
    chk({tag, ".FetchCnt"}, FetchCnt, 0);
`endif
  endtask
  initial begin
    reset = 1'b1; stallF = 0; stallD = 0; FlushD = 0; PcSrcE = 0; PerfClr = 0; PCTargetE = '0;
    #12;
    chk("rst.PCF", PCF, 32'h0);
    chk_d("rst", 32'h13, 0, 0, 0);
    chk_cnt("rst", 0, 0, 0);
    #5 reset = 1'b0;
    // 1: free-running fetch
    step(); chk("t1a.PCF", PCF, 32'h4); chk_d("t1a", im(0), 0, 4, 1);
    step(); chk("t1b.PCF", PCF, 32'h8); chk_d("t1b", im(4), 4, 8, 1);
    step(); chk("t1c.PCF", PCF, 32'hC); chk_d("t1c", im(8), 8, 12, 1);
    step(); chk("t2pre.PCF", PCF, 32'h10);
    // 2: stall both stages two edges
    stallF = 1; stallD = 1;
    step(); chk("t2a.PCF", PCF, 32'h10); chk_d("t2a", im(12), 12, 16, 1);
    step(); chk("t2b.PCF", PCF, 32'h10); chk_d("t2b", im(12), 12, 16, 1);
    stallF = 0; stallD = 0;
    step(); chk("t2c.PCF", PCF, 32'h14); chk_d("t2c", im(16), 16, 20, 1);
    // 3: redirect + flush
    PcSrcE = 1; PCTargetE = 32'h100; FlushD = 1;
    step(); chk("t3a.PCF", PCF, 32'h100); chk_d("t3a", 32'h13, 0, 0, 0);
    PcSrcE = 0; FlushD = 0;
    step(); chk("t3b.PCF", PCF, 32'h104); chk_d("t3b", im(32'h100), 32'h100, 32'h104, 1);
    // 4: redirect beats stallF, flush beats stallD
    PcSrcE = 1; PCTargetE = 32'h200; FlushD = 1; stallF = 1; stallD = 1;
    step(); chk("t4a.PCF", PCF, 32'h200); chk_d("t4a", 32'h13, 0, 0, 0);
    PcSrcE = 0; FlushD = 0;
    step(); chk("t4b.PCF", PCF, 32'h200); chk_d("t4b", 32'h13, 0, 0, 0);
    stallF = 0; stallD = 0;
    step(); chk("t4c.PCF", PCF, 32'h204); chk_d("t4c", im(32'h200), 32'h200, 32'h204, 1);
    // misaligned target passes through
    PcSrcE = 1; PCTargetE = 32'h103;
    step(); chk("mis.PCF", PCF, 32'h103); chk_d("mis", im(32'h204), 32'h204, 32'h208, 1);
    // 5: wrap at top of address space
    PCTargetE = 32'hFFFF_FFFC;
    step(); chk("t5a.PCF", PCF, 32'hFFFF_FFFC);
    PcSrcE = 0;
    step(); chk("t5b.PCF", PCF, 32'h0); chk_d("t5b", im(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1);
    // 6: counters; clear wins over same-cycle accept
    PerfClr = 1;
    step(); chk_cnt("clr", 0, 0, 0);
    PerfClr = 0; stallF = 1; stallD = 1;
    repeat (3) step();
    stallF = 0; stallD = 0; FlushD = 1;
    step();
    stallD = 1;
    step();
    stallD = 0; FlushD = 0;
    repeat (4) step();
    chk_cnt("t6", 3, 2, 4);
    PerfClr = 1; stallD = 1;
    step(); chk_cnt("clr2", 0, 0, 0);
    PerfClr = 0; stallF = 1;
    step(); chk_cnt("stl", 1, 0, 0);
    // async reset mid-stall, away from any clock edge
    #2 reset = 1;
    #1;
    chk("arst.PCF", PCF, 32'h0);
    chk_d("arst", 32'h13, 0, 0, 0);
    chk_cnt("arst", 0, 0, 0);
    stallF = 0; stallD = 0;
    step(); chk("arst_hold.PCF", PCF, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
